// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control block.
//   pipe_state_e : controller state encoding (RUN / MDWAIT)
//   REG_W        : architectural register index width
//   MD_MAX_DEF   : default cap on cycles spent waiting for mult/div
//   CNT_W_DEF    : default performance counter width
package pipe_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    MDWAIT = 1'b1
  } pipe_state_e;

  localparam int REG_W      = 5;
  localparam int MD_MAX_DEF = 40;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
//   clk   : clock
//   clr_i : synchronous clear, wins over increment
//   inc_i : increment request for this cycle
//   cnt_o : current count; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Control end of the five-stage latch chain (PC, F/D, D/X, X/M, M/W).
// Produces per-stage enables and clears to resolve load-use stalls,
// taken-branch flushes and multi-cycle mult/div freezes, and keeps
// saturating stall/flush counters.
//
// Ports:
//   clk, clr              : clock and synchronous active-high reset
//   fd_rs1/2, fd_use1/2   : source registers of the F/D instruction
//   dx_load, dx_rd        : D/X instruction is a load, and its destination
//   br_taken              : X-stage branch/jump resolved taken
//   md_start, md_ready    : mult/div first cycle / result valid
//   pc_en..mw_en          : stage enables (combinational)
//   fd_clr..xm_clr        : stage clears, bubble insert (combinational)
//   md_timeout            : sticky, set when a mult/div wait hit MD_MAX
//   stall_cnt, flush_cnt  : saturating performance counters
//   dbg_state             : current controller state, for observation
//
// No handshakes here: every input is a level valid for the current cycle,
// and every stage-control output applies to the same cycle's latch update.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_MAX = MD_MAX_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [REG_W-1:0] fd_rs1,
  input  logic [REG_W-1:0] fd_rs2,
  input  logic             fd_use1,
  input  logic             fd_use2,
  input  logic             dx_load,
  input  logic [REG_W-1:0] dx_rd,
  input  logic             br_taken,
  input  logic             md_start,
  input  logic             md_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_clr,
  output logic             dx_clr,
  output logic             xm_clr,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output pipe_state_e      dbg_state
);

  localparam int MDT_W = (MD_MAX > 2) ? $clog2(MD_MAX) : 1;
  localparam logic [MDT_W-1:0] MDT_LAST = MDT_W'(MD_MAX - 1);

  pipe_state_e      state_q, state_d;
  logic [MDT_W-1:0] md_t_q, md_t_d;
  logic             md_timeout_q, md_timeout_d;
  logic             luh;
  logic             flush_inc;
  logic             stall_inc;

  // A load into x0 never creates a dependency.
  assign luh = dx_load && (dx_rd != '0) &&
               ((fd_use1 && (fd_rs1 == dx_rd)) ||
                (fd_use2 && (fd_rs2 == dx_rd)));

  always_comb begin
    pc_en        = 1'b1;
    fd_en        = 1'b1;
    dx_en        = 1'b1;
    xm_en        = 1'b1;
    mw_en        = 1'b1;
    fd_clr       = 1'b0;
    dx_clr       = 1'b0;
    xm_clr       = 1'b0;
    state_d      = state_q;
    md_t_d       = md_t_q;
    md_timeout_d = md_timeout_q;
    flush_inc    = 1'b0;

    if (clr) begin
      pc_en        = 1'b0;
      fd_en        = 1'b0;
      dx_en        = 1'b0;
      xm_en        = 1'b0;
      mw_en        = 1'b0;
      fd_clr       = 1'b1;
      dx_clr       = 1'b1;
      xm_clr       = 1'b1;
      state_d      = RUN;
      md_t_d       = '0;
      md_timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (br_taken) begin
            // Squash the two younger instructions; the branch itself moves on.
            fd_clr    = 1'b1;
            dx_clr    = 1'b1;
            flush_inc = 1'b1;
          end else if (md_start && !md_ready) begin
            // Freeze front end, keep a bubble in X/M while the unit works.
            pc_en   = 1'b0;
            fd_en   = 1'b0;
            dx_en   = 1'b0;
            xm_clr  = 1'b1;
            state_d = MDWAIT;
            md_t_d  = MDT_W'(1);
          end else if (md_start && md_ready) begin
            // Single-cycle op: nothing to resolve.
          end else if (luh) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_clr = 1'b1;
          end
        end
        MDWAIT: begin
          if (md_ready) begin
            state_d = RUN;
            md_t_d  = '0;
          end else if (md_t_q == MDT_LAST) begin
            // Give up waiting; release the pipe as if the result arrived.
            md_timeout_d = 1'b1;
            state_d      = RUN;
            md_t_d       = '0;
          end else begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_en  = 1'b0;
            xm_clr = 1'b1;
            md_t_d = md_t_q + MDT_W'(1);
          end
        end
        default: begin
          state_d = RUN;
          md_t_d  = '0;
        end
      endcase
    end
  end

  assign stall_inc = !clr && !pc_en;

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    md_t_q       <= md_t_d;
    md_timeout_q <= md_timeout_d;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (clr),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_i (clr),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt)
  );

  assign md_timeout = md_timeout_q;
  assign dbg_state  = state_q;

endmodule
